mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one single-ported, fixed-latency synchronous memory between the RV32I fetch stage (IF requester) and the memory stage (DM requester). Each cycle it grants at most one request, drives the memory port from the winner, and routes pipelined read data back to the owner. It also raises a fetch-stall request into the hazard logic, and drops in-flight fetch responses on a branch/jump flush.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (DW/8 byte enables)
- MEM_LAT, 1, read latency in cycles from accepted request to valid mem_rdata; legal 1..4
- STARVE_MAX, 3, consecutive denied IF-request cycles before IF takes priority; legal 1..7

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch read request
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  DW/8  store byte enables
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  load data valid
- dm_rdata  out  DW  load data
- flush_if  in  1  discard all in-flight fetch responses (driven from PCSrcE)
- stall_if  out  1  if_req high and if_gnt low this cycle
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after a read with mem_en=1

## Operation
- Handshake: a requester holds req and all request fields stable until it sees gnt. gnt is combinational from req and registered arbitration state, in the same cycle. Withdrawing req before gnt is illegal.
- Priority: DM wins by default. The exception is starve_cnt == STARVE_MAX, when IF wins.
- starve_cnt (3 bits): increments, saturating at STARVE_MAX, each cycle with if_req && !if_gnt. It clears on any if_gnt or when if_req is low.
- Memory drive: when either gnt is high, mem_en=1 and mem_* take the winner's fields. IF always drives mem_we=0 and mem_be=0. When idle, all mem_* are 0.
- Store grants complete in the grant cycle and produce no rvalid.
- Response tracking: owner pipeline of MEM_LAT entries {v, src}, shifted every cycle. Stage 0 loads {1, src} on a read grant and {0, x} otherwise. When the last stage has v=1, mem_rdata routes to if_rdata or dm_rdata with the matching rvalid for one cycle.
- Both rdata outputs carry mem_rdata continuously; only rvalid qualifies them.
- Flush: in a flush_if cycle, clear v on every pipeline entry with src=IF, including the entry being loaded that cycle. Suppress if_rvalid that same cycle as well. DM entries are untouched.
- Reset: while rst_n=0 at a clock edge, the pipeline is cleared and starve_cnt=0. Any outstanding responses are lost, not replayed.

## Timing
- Reset values (registered state after reset): if_rvalid=0, dm_rvalid=0, starve_cnt=0. With no requests, if_gnt, dm_gnt, stall_if and all mem_* are 0.
- Read latency: a grant in cycle N gives rvalid in cycle N+MEM_LAT.
- Throughput: one access per cycle, back-to-back. Up to MEM_LAT reads are outstanding.
- Simultaneous rvalid and new grant in the same cycle are allowed.
- Both requests in the same cycle: one grant only. The loser's req stays high. stall_if=1 if IF lost.
- flush_if in the same cycle as an IF read grant: the grant still occurs (if_gnt=1), but its response is dropped.
- Reset mid-operation: any pending rvalid due after the reset edge is never produced.

## Structure
- rv32i_pkg additions:
  - constants MEM_AW=32, MEM_DW=32, MEM_LAT_DEF=1
  - typedef enum logic {SRC_IF, SRC_DM} mem_src_e
  - typedef struct packed {logic v; mem_src_e src;} mem_tag_t
- One sub-module: mem_resp_tracker, holding the MEM_LAT-deep mem_tag_t pipeline with flush-by-source and the output-stage decode. Arbitration and the starvation counter stay in the top.

## Test plan
- MEM_LAT=2. IF-only reads to 0x0, 0x4, 0x8 back-to-back.
  - Required: if_gnt=1 in cycles 0–2.
  - Required: if_rvalid in cycles 2–4 with the matching data; stall_if never 1.
- Same cycle if_req (0x10) and dm load (0x100).
  - Required: dm_gnt=1, if_gnt=0, stall_if=1.
  - Required next cycle: if_gnt=1.
  - Required: dm_rvalid precedes if_rvalid by one cycle.
- STARVE_MAX=3. dm_req held high continuously with if_req high.
  - Required: IF denied for 3 cycles, then granted in the 4th cycle while dm_gnt=0.
  - Required: starve_cnt returns to 0.
- MEM_LAT=3. IF reads granted at cycles 0 and 1, DM load at cycle 2, flush_if=1 at cycle 2.
  - Required: no if_rvalid in cycles 3–4.
  - Required: dm_rvalid=1 at cycle 5.
- DM store (be=4'b0011, data 0xDEADBEEF, addr 0x20).
  - Required: mem_we=1, mem_be=4'b0011, mem_wdata=0xDEADBEEF in the grant cycle.
  - Required: no dm_rvalid at any later cycle.
- Read granted at cycle 0 (MEM_LAT=2), rst_n=0 at cycle 1.
  - Required: no rvalid at cycle 2.
  - Required: all outputs 0 until a new request.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I types for the memory port arbiter slice.
// Holds the memory defaults, the requester source tag and the response tag type.
package rv32i_pkg;

    localparam int MEM_AW      = 32;
    localparam int MEM_DW      = 32;
    localparam int MEM_LAT_DEF = 1;

    typedef enum logic {
        SRC_IF,
        SRC_DM
    } mem_src_e;

    typedef struct packed {
        logic     v;
        mem_src_e src;
    } mem_tag_t;

    // Kill a fetch-owned tag while a branch/jump flush is active.
    function automatic mem_tag_t dropIf(mem_tag_t t, logic flush);
        dropIf = t;
        if (flush && (t.src == SRC_IF)) begin
            dropIf.v = 1'b0;
        end
    endfunction

endpackage

// File: rtl/mem_resp_tracker.sv
// Response owner pipeline: one tag per cycle of memory read latency.
// Ports: clk/rst_n (sync active-low), rdLoad/rdSrc (read grant this cycle),
// flushIf (drop fetch tags), ifValid/dmValid (response owner at the output stage).
module mem_resp_tracker
    import rv32i_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rdLoad,
    input  mem_src_e rdSrc,
    input  logic     flushIf,
    output logic     ifValid,
    output logic     dmValid
);

    mem_tag_t [MEM_LAT-1:0] pipe;
    mem_tag_t               newTag;
    mem_tag_t               head;

    always_comb begin
        newTag.v   = rdLoad;
        newTag.src = rdLoad ? rdSrc : SRC_IF;
    end

    // Flush is applied as tags shift, so every fetch tag in flight,
    // including the one entering this cycle, is gone after the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= dropIf(newTag, flushIf);
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe[i] <= dropIf(pipe[i-1], flushIf);
            end
        end
    end

    assign head = pipe[MEM_LAT-1];

    // The tag leaving this cycle is still registered, so a same-cycle
    // flush has to mask the fetch response combinationally.
    always_comb begin
        ifValid = head.v && (head.src == SRC_IF) && !flushIf;
        dmValid = head.v && (head.src == SRC_DM);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between fetch (IF) and memory stage (DM).
// Ports: if_* fetch reads, dm_* loads/stores, flush_if drops fetch responses,
// stall_if to hazard unit, mem_* drive the memory, mem_rdata returns MEM_LAT later.
module mem_port_arbiter
    import rv32i_pkg::*;
#(
    parameter int AW         = MEM_AW,
    parameter int DW         = MEM_DW,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [DW-1:0]   dm_rdata,
    input  logic            flush_if,
    output logic            stall_if,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0] starveCnt;
    logic       ifWins;
    logic       rdLoad;
    mem_src_e   rdSrc;

    // DM has priority unless fetch has been starved long enough.
    always_comb begin
        ifWins = if_req && (!dm_req || (starveCnt == STARVE_LIM));
        if_gnt = ifWins;
        dm_gnt = dm_req && !ifWins;
    end

    assign stall_if = if_req && !if_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starveCnt <= '0;
        end else if (stall_if) begin
            if (starveCnt != STARVE_LIM) begin
                starveCnt <= starveCnt + 3'd1;
            end
        end else begin
            starveCnt <= '0;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            if_gnt: begin
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end
            dm_gnt: begin
                mem_en    = 1'b1;
                mem_we    = dm_we;
                mem_be    = dm_be;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end
            default: ;
        endcase
    end

    // Stores finish in the grant cycle; only reads take a tracker slot.
    always_comb begin
        rdLoad = if_gnt || (dm_gnt && !dm_we);
        rdSrc  = if_gnt ? SRC_IF : SRC_DM;
    end

    mem_resp_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdLoad  (rdLoad),
        .rdSrc   (rdSrc),
        .flushIf (flush_if),
        .ifValid (if_rvalid),
        .dmValid (dm_rvalid)
    );

    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT=2 and MEM_LAT=3.
// Both instances share stimulus; a scoreboard predicts grants and responses.
module tb_mem_port_arbiter;

    localparam int SMAX = 3;

    typedef struct {
        int          due;
        bit          isIf;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        flush_if;

    logic        ifGnt [2];
    logic        ifRv  [2];
    logic [31:0] ifRd  [2];
    logic        dmGnt [2];
    logic        dmRv  [2];
    logic [31:0] dmRd  [2];
    logic        stall [2];
    logic        mEn   [2];
    logic        mWe   [2];
    logic [3:0]  mBe   [2];
    logic [31:0] mAddr [2];
    logic [31:0] mWd   [2];
    logic [31:0] mRd   [2];

    logic [31:0] dlyA [2];
    logic [31:0] dlyB [3];

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    starve = 0;
    int    denyRun = 0;
    int    lastDeny = -1;
    bit    armed = 0;
    resp_t sb [2][$];
    req_t  ifQ[$];
    req_t  dmQ[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] dataOf(logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    always @(posedge clk) begin
        dlyA[0] <= mAddr[0];
        dlyA[1] <= dlyA[0];
        dlyB[0] <= mAddr[1];
        dlyB[1] <= dlyB[0];
        dlyB[2] <= dlyB[1];
    end

    assign mRd[0] = dataOf(dlyA[1]);
    assign mRd[1] = dataOf(dlyB[2]);

    mem_port_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(SMAX)
    ) uA (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(ifGnt[0]),
        .if_rvalid(ifRv[0]), .if_rdata(ifRd[0]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dmGnt[0]),
        .dm_rvalid(dmRv[0]), .dm_rdata(dmRd[0]),
        .flush_if(flush_if), .stall_if(stall[0]),
        .mem_en(mEn[0]), .mem_we(mWe[0]), .mem_be(mBe[0]),
        .mem_addr(mAddr[0]), .mem_wdata(mWd[0]), .mem_rdata(mRd[0])
    );

    mem_port_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(SMAX)
    ) uB (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(ifGnt[1]),
        .if_rvalid(ifRv[1]), .if_rdata(ifRd[1]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dmGnt[1]),
        .dm_rvalid(dmRv[1]), .dm_rdata(dmRd[1]),
        .flush_if(flush_if), .stall_if(stall[1]),
        .mem_en(mEn[1]), .mem_we(mWe[1]), .mem_be(mBe[1]),
        .mem_addr(mAddr[1]), .mem_wdata(mWd[1]), .mem_rdata(mRd[1])
    );

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[lat%0d] cyc %0d observed %0h expected %0h",
                   tag, k + 2, cyc, obs, exp);
        end
    endtask

    task automatic pushIf(logic [31:0] a);
        ifQ.push_back('{1'b0, 4'h0, a, 32'h0});
    endtask

    task automatic pushDm(logic we, logic [3:0] be, logic [31:0] a, logic [31:0] d);
        dmQ.push_back('{we, be, a, d});
    endtask

    // One clock: present queued requests, check at negedge, advance.
    task automatic tick(input bit fl);
        bit          eIf;
        bit          eDm;
        bit          eIfRv;
        bit          eDmRv;
        logic [31:0] eData;
        eIf = 0;
        eDm = 0;
        if_req   = ifQ.size() > 0;
        if_addr  = if_req ? ifQ[0].addr : 32'h0;
        dm_req   = dmQ.size() > 0;
        dm_we    = dm_req ? dmQ[0].we : 1'b0;
        dm_be    = dm_req ? dmQ[0].be : 4'h0;
        dm_addr  = dm_req ? dmQ[0].addr : 32'h0;
        dm_wdata = dm_req ? dmQ[0].wdata : 32'h0;
        flush_if = fl;
        @(negedge clk);
        if (armed) begin
            eIf = if_req && (!dm_req || starve == SMAX);
            eDm = dm_req && !eIf;
            for (int k = 0; k < 2; k++) begin
                if (eIf || (eDm && !dm_we))
                    sb[k].push_back('{cyc + k + 2, eIf,
                                      dataOf(eIf ? if_addr : dm_addr)});
                if (fl)
                    for (int i = sb[k].size() - 1; i >= 0; i--)
                        if (sb[k][i].isIf) sb[k].delete(i);
                chk("if_gnt", k, ifGnt[k], eIf);
                chk("dm_gnt", k, dmGnt[k], eDm);
                chk("stall_if", k, stall[k], if_req && !eIf);
                chk("mem_en", k, mEn[k], eIf || eDm);
                chk("mem_we", k, mWe[k], eDm && dm_we);
                chk("mem_be", k, mBe[k], eDm ? dm_be : 4'h0);
                chk("mem_addr", k, mAddr[k],
                    eIf ? if_addr : (eDm ? dm_addr : 32'h0));
                chk("mem_wdata", k, mWd[k], eDm ? dm_wdata : 32'h0);
                eIfRv = 0;
                eDmRv = 0;
                eData = 32'h0;
                if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
                    eIfRv = sb[k][0].isIf;
                    eDmRv = !sb[k][0].isIf;
                    eData = sb[k][0].data;
                    void'(sb[k].pop_front());
                end
                chk("if_rvalid", k, ifRv[k], eIfRv);
                chk("dm_rvalid", k, dmRv[k], eDmRv);
                if (eIfRv) chk("if_rdata", k, ifRd[k], eData);
                if (eDmRv) chk("dm_rdata", k, dmRd[k], eData);
            end
            if (if_req && !ifGnt[0]) denyRun++;
            if (ifGnt[0]) begin
                lastDeny = denyRun;
                denyRun = 0;
            end
            if (if_req && !eIf) starve = (starve < SMAX) ? starve + 1 : SMAX;
            else starve = 0;
            if (!rst_n) begin
                starve = 0;
                sb[0].delete();
                sb[1].delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (eIf) void'(ifQ.pop_front());
        if (eDm) void'(dmQ.pop_front());
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        tick(1'b0);
        tick(1'b0);
        armed = 1;
        tick(1'b0);
        rst_n = 1'b1;
        run(2);

        // Back-to-back fetches.
        pushIf(32'h0);
        pushIf(32'h4);
        pushIf(32'h8);
        run(7);

        // Simultaneous fetch and load: DM first, IF next cycle.
        pushIf(32'h10);
        pushDm(1'b0, 4'h0, 32'h100, 32'h0);
        run(6);

        // Continuous DM traffic against one waiting fetch.
        for (int i = 0; i < 6; i++)
            pushDm(1'b0, 4'h0, 32'h200 + 32'(i * 4), 32'h0);
        pushIf(32'h300);
        run(11);
        chk("starve_wait", 0, 32'(lastDeny), 32'd3);

        // Two fetches in flight, then a load with flush.
        pushIf(32'h40);
        pushIf(32'h44);
        tick(1'b0);
        tick(1'b0);
        pushDm(1'b0, 4'h0, 32'h140, 32'h0);
        tick(1'b1);
        run(5);

        // Store.
        pushDm(1'b1, 4'b0011, 32'h20, 32'hDEADBEEF);
        run(5);

        // Mixed stream with a flush in the middle.
        pushIf(32'h500);
        pushIf(32'h504);
        pushIf(32'h508);
        pushDm(1'b0, 4'h0, 32'h600, 32'h0);
        pushDm(1'b1, 4'b1111, 32'h604, 32'h12345678);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        run(8);

        // Reset with a read outstanding.
        pushIf(32'h80);
        tick(1'b0);
        rst_n = 1'b0;
        tick(1'b0);
        rst_n = 1'b1;
        run(5);

        chk("drain", 0, 32'(sb[0].size()), 32'd0);
        chk("drain", 1, 32'(sb[1].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
